// File: rtl/hw2_result_acc_if.sv
// Handshake bundle for hw2_result_acc: sample input stream plus frame-summary output.
// master drives samples and out_ready; slave (the accumulator) drives in_ready and the summary.
interface hw2_result_acc_if #(
  parameter int CNT_W = 9
);
  localparam int SUM_W = 16 + CNT_W;

  logic             in_valid;
  logic [15:0]      in_d;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic [15:0]      out_max;
  logic             out_trunc;

  modport master (
    output in_valid, in_d, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_max, out_trunc
  );

  modport slave (
    input  in_valid, in_d, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_max, out_trunc
  );
endinterface

// File: rtl/hw2_result_acc.sv
// Frame accumulator: sums, counts and (with HW2_RESULT_ACC_MAX_EN) tracks the max of unsigned
// samples; a frame closes on in_last or at 2^CNT_W-1 samples, then the summary is held until taken.
module hw2_result_acc #(
  parameter int CNT_W = 9
) (
  input  logic              CLK,
  input  logic              reset,
  hw2_result_acc_if.slave   bus
);
  localparam int SUM_W = 16 + CNT_W;
  localparam logic [CNT_W-1:0] LIMIT = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             trunc_q, trunc_d;

  logic             in_ready_w;
  logic             out_valid_w;
  logic             accept;
  logic             first;
  logic [CNT_W-1:0] count_nxt;
  logic             at_limit;
  logic             close;

  assign accept    = bus.in_valid && in_ready_w;
  assign first     = (state_q == S_IDLE);
  assign count_nxt = first ? CNT_W'(1) : count_q + CNT_W'(1);
  assign at_limit  = (count_nxt == LIMIT);
  assign close     = bus.in_last || at_limit;

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACC: if (accept) state_d = close ? S_HOLD : S_ACC;
      S_HOLD:        if (bus.out_ready) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // FSM: outputs; in_ready is also gated by reset so nothing is taken while held in reset
  always_comb begin
    in_ready_w  = reset && (state_q != S_HOLD);
    out_valid_w = (state_q == S_HOLD);
  end

  // The first beat of a frame overwrites the previous summary rather than adding to it.
  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    trunc_d = trunc_q;
    if (accept) begin
      sum_d   = first ? SUM_W'(bus.in_d) : sum_q + SUM_W'(bus.in_d);
      count_d = count_nxt;
      trunc_d = at_limit && !bus.in_last;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      sum_q   <= '0;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
    end
  end

`ifdef HW2_RESULT_ACC_MAX_EN
  logic [15:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (accept && (first || (bus.in_d > max_q))) max_d = bus.in_d;
  end

  always_ff @(posedge CLK) begin
    if (!reset) max_q <= '0;
    else        max_q <= max_d;
  end

  assign bus.out_max = max_q;
`else
  assign bus.out_max = 16'h0000;
`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;
  assign bus.out_trunc = trunc_q;
endmodule

// File: tb/tb_hw2_result_acc.sv
// Scoreboard bench for hw2_result_acc: a frame-level reference model queues expected summaries,
// a monitor pops and compares them on every output handshake.
module tb_hw2_result_acc;
  localparam int CNT_W = 9;
  localparam int LIMIT = (1 << CNT_W) - 1;

  typedef struct {
    longint sum;
    int     count;
    int     max;
    bit     trunc;
  } frame_t;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  hw2_result_acc_if #(.CNT_W(CNT_W)) ifc ();

  hw2_result_acc #(.CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  frame_t exp_q[$];
  int     cur_frame[$];
  int     rdy_mode = 2;   // 0 random, 1 held low, 2 held high

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: gather a frame's samples, summarise them when the frame closes.
  function automatic bit model_accept(input int d, input bit last);
    frame_t f;
    cur_frame.push_back(d);
    if (last || cur_frame.size() == LIMIT) begin
      f.sum = 0;
      f.max = 0;
      foreach (cur_frame[i]) begin
        f.sum += cur_frame[i];
        if (cur_frame[i] > f.max) f.max = cur_frame[i];
      end
      f.count = cur_frame.size();
      f.trunc = !last;
`ifndef HW2_RESULT_ACC_MAX_EN
      f.max = 0;
`endif
      exp_q.push_back(f);
      cur_frame.delete();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       ifc.out_ready = ($urandom_range(0, 3) != 0);
      1:       ifc.out_ready = 1'b0;
      default: ifc.out_ready = 1'b1;
    endcase
  end

  // Monitor: compares each taken summary and checks that a stalled summary does not move.
  bit          hold_pend = 1'b0;
  logic [24:0] snap_sum;
  logic [8:0]  snap_cnt;
  logic [15:0] snap_max;
  logic        snap_trunc;
  always @(negedge CLK) begin
    frame_t e;
    if (!reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("stall_valid", ifc.out_valid, 1);
        check("stall_sum",   ifc.out_sum,   snap_sum);
        check("stall_count", ifc.out_count, snap_cnt);
        check("stall_max",   ifc.out_max,   snap_max);
        check("stall_trunc", ifc.out_trunc, snap_trunc);
      end
      if (ifc.out_valid) begin
        check("in_ready_in_hold", ifc.in_ready, 0);
        if (ifc.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_summary", ifc.out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("sum",   ifc.out_sum,   e.sum);
            check("count", ifc.out_count, e.count);
            check("max",   ifc.out_max,   e.max);
            check("trunc", ifc.out_trunc, e.trunc);
          end
        end
      end
      hold_pend  = ifc.out_valid && !ifc.out_ready;
      snap_sum   = ifc.out_sum;
      snap_cnt   = ifc.out_count;
      snap_max   = ifc.out_max;
      snap_trunc = ifc.out_trunc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input bit last);
    int w = 0;
    bit closed;
    ifc.in_valid = 1'b1;
    ifc.in_d     = d;
    ifc.in_last  = last;
    while (!ifc.in_ready && w < 1000) begin
      tick(1);
      w++;
    end
    if (!ifc.in_ready) begin
      check("in_ready_timeout", ifc.in_ready, 1);
      ifc.in_valid = 1'b0;
      return;
    end
    tick(1);
    ifc.in_valid = 1'b0;
    closed = model_accept(int'(d), last);
    check(closed ? "latency_valid" : "no_early_valid", ifc.out_valid, closed ? 1 : 0);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || ifc.out_valid) && w < 2000) begin
      tick(1);
      w++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1);
    check("rst_valid", ifc.out_valid, 0);
    check("rst_sum",   ifc.out_sum,   0);
    check("rst_count", ifc.out_count, 0);
    check("rst_max",   ifc.out_max,   0);
    check("rst_trunc", ifc.out_trunc, 0);
    check("rst_ready", ifc.in_ready,  0);
    cur_frame.delete();
    reset = 1'b1;
    #1;
    check("ready_after_rst", ifc.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_d     = '0;
    ifc.in_last  = 1'b0;
    ifc.out_ready = 1'b1;
    tick(2);
    do_reset();

    // Three-beat frame with the consumer always ready; summary must be a one-cycle pulse.
    rdy_mode = 2;
    tick(1);
    send_beat(16'h0010, 0);
    send_beat(16'h0020, 0);
    send_beat(16'h0030, 1);
    tick(1);
    check("pulse_one_cycle", ifc.out_valid, 0);
    check("ready_after_hold", ifc.in_ready, 1);

    // Stalled single-beat frame; a beat offered during the stall must wait.
    rdy_mode = 1;
    tick(1);
    send_beat(16'hFFFF, 1);
    ifc.in_valid = 1'b1;
    ifc.in_d     = 16'h1234;
    ifc.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", ifc.out_valid, 1);
      check("hold_no_ready", ifc.in_ready, 0);
      tick(1);
    end
    rdy_mode = 2;
    send_beat(16'h1234, 1);
    drain();

    // Gap inside a frame, then a fresh frame must not inherit anything.
    send_beat(16'h0005, 0);
    tick(3);
    send_beat(16'h0003, 1);
    send_beat(16'h0001, 1);
    drain();

    // Counter-limit truncation.
    for (int i = 0; i < LIMIT; i++) send_beat(16'hFFFF, 0);
    drain();

    // Reset aborts a partial frame.
    send_beat(16'h0100, 0);
    send_beat(16'h0200, 0);
    do_reset();
    send_beat(16'h0007, 1);
    drain();

    // Random frames, random gaps and random consumer stalls.
    rdy_mode = 0;
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        logic [15:0] d;
        d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
        send_beat(d, b == len - 1);
        tick($urandom_range(0, 2));
      end
    end
    rdy_mode = 2;
    drain();
    tick(2);
    check("no_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hw2_result_acc.md
HW2_RESULT_ACC -- requirements
Module: hw2_result_acc

Interface
REQ-001 The block SHALL have parameter CNT_W, default 9, giving the sample-counter width; the frame limit is 2^CNT_W-1.
REQ-002 The block SHALL derive SUM_W = 16+CNT_W as a localparam, with no overflow possible.
REQ-003 CLK  input  1  clock; all state SHALL change on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  the upstream datapath result on in_d is valid.
REQ-006 in_d  input  16  result d from the add/sub-multiply stage, unsigned.
REQ-007 in_last  input  1  marks the final sample of a frame; it is qualified by in_valid.
REQ-008 in_ready  output  1  the block can accept a sample this cycle.
REQ-009 out_valid  output  1  the frame summary is held on the out_* buses.
REQ-010 out_ready  input  1  the downstream consumer takes the summary.
REQ-011 out_sum  output  SUM_W  sum of all in_d values accepted in the frame.
REQ-012 out_count  output  CNT_W  number of samples accepted in the frame.
REQ-013 out_max  output  16  largest in_d value accepted in the frame.
REQ-014 out_trunc  output  1  the frame was closed by the counter limit, not by in_last.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, ACC and HOLD.
REQ-016 An input beat SHALL be accepted when in_valid and in_ready are both high.
REQ-017 in_ready SHALL be high in IDLE and ACC, and low in HOLD.
REQ-018 IDLE SHALL move to ACC on an accepted beat with in_last=0.
REQ-019 IDLE SHALL move to HOLD on an accepted beat with in_last=1, producing a one-sample frame.
REQ-020 ACC SHALL stay in ACC on an accepted beat with in_last=0 and count+1 < 2^CNT_W-1.
REQ-021 ACC SHALL move to HOLD on an accepted beat with in_last=1.
REQ-022 ACC SHALL also move to HOLD when the accepted beat brings the count to 2^CNT_W-1 with in_last=0; in that case out_trunc SHALL be 1.
REQ-023 HOLD SHALL move to IDLE on out_valid and out_ready both high.
REQ-024 On every accepted beat, the block SHALL update sum += in_d, count += 1, and max = larger of max and in_d.
REQ-025 The first beat of a frame SHALL load sum=in_d, count=1 and max=in_d, discarding the previous frame's values.
REQ-026 out_valid SHALL be high exactly while in HOLD.
REQ-027 out_valid SHALL go high in the cycle after the closing beat is accepted (latency 1), and that sum SHALL include the closing beat.
REQ-028 The out_* buses SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 Beats presented during HOLD SHALL NOT be accepted and SHALL NOT alter state.
REQ-030 in_valid=0 in ACC SHALL hold all state unchanged, so gaps of any length are allowed.
REQ-031 If out_ready is already high on the first HOLD cycle, out_valid SHALL be exactly one cycle wide.
REQ-032 in_ready SHALL return high in the following IDLE cycle, so there is no same-cycle bypass.
REQ-033 in_d SHALL never be sign-extended; all arithmetic SHALL be unsigned zero-extended.

Reset
REQ-034 When reset=0 at a rising edge, the block SHALL enter IDLE with out_sum=0, out_count=0, out_max=0, out_trunc=0 and out_valid=0.
REQ-035 in_ready SHALL be 0 while reset=0 and 1 in the first cycle after reset=1.
REQ-036 Reset asserted in ACC or HOLD SHALL abort the frame; a partial frame SHALL never be reported.

Configuration
REQ-037 Macro HW2_RESULT_ACC_MAX_EN SHALL control maximum tracking.
REQ-038 When HW2_RESULT_ACC_MAX_EN is defined, the max register and its compare logic SHALL be built and behave per REQ-024/025.
REQ-039 When HW2_RESULT_ACC_MAX_EN is undefined, out_max SHALL be tied to 16'h0000 with no register or comparator synthesised; all other behaviour SHALL be identical.

Verification
REQ-040 Frame in_d=0010,0020,0030 (last on third), out_ready=1 -> out_valid one cycle after third beat; sum=0x60, count=3, max=0x30, trunc=0.
REQ-041 Single beat in_d=FFFF with last=1, out_ready=0 for 5 cycles -> out_valid held 5 cycles with stable sum=FFFF, count=1, max=FFFF; in_ready=0 throughout; beats offered are ignored.
REQ-042 511 beats of FFFF with no last (CNT_W=9) -> HOLD after the 511th beat; sum=0x1FEFE01, count=511, trunc=1.
REQ-043 Beats 0005,(gap 3 cycles),0003 last -> sum=8, count=2, max=5; next frame 0001 last -> sum=1, count=1, max=1 (no carry-over).
REQ-044 reset=0 for one cycle mid-frame after beats 0100,0200 -> all outputs 0, IDLE; subsequent frame 0007 last -> sum=7, count=1.
REQ-045 Build without HW2_RESULT_ACC_MAX_EN, rerun REQ-040 -> out_max=0, sum/count unchanged.
